// File: rtl/dmem_resp.sv
// ============================================================================
// dmem_resp : M-stage data-memory sequencer (align check, SRAM handshake, load extend)
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_resp #(
    parameter int GNT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValidM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic        ReqReadyM,
    output logic        StallM,
    output logic        RespValidM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_gnt
);

    localparam int CNT_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RDATA = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        addr_lo;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic              illegal;
    logic              timeout;
    logic [3:0]        be_nxt;
    logic [31:0]       wdata_nxt;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_ext;

    // Request decode on the incoming (not yet latched) request
    always_comb begin
        illegal   = 1'b1;
        be_nxt    = 4'b1111;
        wdata_nxt = WriteDataM;
        case (funct3M)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = AddrM[0];
            3'b010:  illegal = |AddrM[1:0];
            3'b100:  illegal = MemWriteM;
            3'b101:  illegal = MemWriteM | AddrM[0];
            default: illegal = 1'b1;
        endcase
        if (MemWriteM) begin
            case (funct3M[1:0])
                2'b00: begin
                    be_nxt    = 4'b0001 << AddrM[1:0];
                    wdata_nxt = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    be_nxt    = AddrM[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt = {2{WriteDataM[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (addr_lo)
            2'd0: rd_byte = mem_rdata[7:0];
            2'd1: rd_byte = mem_rdata[15:8];
            2'd2: rd_byte = mem_rdata[23:16];
            2'd3: rd_byte = mem_rdata[31:24];
            default: ;
        endcase
        rd_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_ext = {24'd0, rd_byte};
            3'b101:  load_ext = {16'd0, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    assign timeout = (cnt == CNT_W'(GNT_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ReqValidM) state_nxt = illegal ? DONE : REQ;
            REQ: begin
                if (mem_gnt)      state_nxt = we_q ? DONE : RDATA;
                else if (timeout) state_nxt = DONE;
            end
            RDATA:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    assign ReqReadyM  = (state == IDLE);
    assign RespValidM = (state == DONE);
    assign mem_en     = (state == REQ);
    assign mem_we     = (state == REQ) & we_q;
    // Idle term is gated by reset so StallM reads 0 while reset is held
    assign StallM     = ((state == IDLE) & ReqValidM & reset) | (state == REQ) | (state == RDATA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            addr_lo   <= 2'd0;
            funct3_q  <= 3'd0;
            we_q      <= 1'b0;
            mem_be    <= 4'd0;
            mem_addr  <= 30'd0;
            mem_wdata <= 32'd0;
            ReadDataM <= 32'd0;
            MisalignM <= 1'b0;
            BusErrM   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ReqValidM) begin
                    addr_lo  <= AddrM[1:0];
                    funct3_q <= funct3M;
                    we_q     <= MemWriteM;
                    cnt      <= '0;
                    if (illegal) begin
                        MisalignM <= 1'b1;
                        BusErrM   <= 1'b0;
                    end else begin
                        mem_addr  <= AddrM[31:2];
                        mem_be    <= be_nxt;
                        mem_wdata <= wdata_nxt;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        if (we_q) begin
                            MisalignM <= 1'b0;
                            BusErrM   <= 1'b0;
                        end
                    end else if (timeout) begin
                        MisalignM <= 1'b0;
                        BusErrM   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RDATA: begin
                    ReadDataM <= load_ext;
                    MisalignM <= 1'b0;
                    BusErrM   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_resp.sv
// ============================================================================
// tb_dmem_resp : directed vector bench for dmem_resp
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqValidM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] AddrM, WriteDataM;
    logic        ReqReadyM, StallM, RespValidM, MisalignM, BusErrM;
    logic [31:0] ReadDataM;
    logic        mem_en, mem_we, mem_gnt;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;

    dmem_resp #(.GNT_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .ReqValidM(ReqValidM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .AddrM(AddrM), .WriteDataM(WriteDataM),
        .ReqReadyM(ReqReadyM), .StallM(StallM), .RespValidM(RespValidM),
        .ReadDataM(ReadDataM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_gnt(mem_gnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;     // REQ cycles without grant; 255 = never grant
        logic [3:0]  be;
        logic [29:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] rd;      // ReadDataM after completion
        logic        mis;
        logic        berr;
        int          lat;     // cycles from accept to RespValidM
        int          en;      // cycles with mem_en high
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int   k = 1;
        int   en_cycles = 0;
        bit   done = 0;
        bit   stable_ok = 1;
        bit   granted_prev = 0;
        @(negedge clk);
        ReqValidM  = 1'b1;
        MemWriteM  = v.we;
        funct3M    = v.f3;
        AddrM      = v.addr;
        WriteDataM = v.wdata;
        mem_gnt    = 1'b0;
        mem_rdata  = 32'h5A5A_5A5A;
        #1;
        check($sformatf("v%0d ready", id), {31'd0, ReqReadyM}, 32'd1);
        check($sformatf("v%0d stall_idle", id), {31'd0, StallM}, 32'd1);
        @(negedge clk);
        ReqValidM = 1'b0;
        while (!done && k <= 40) begin
            mem_rdata    = granted_prev ? v.rdata : 32'h5A5A_5A5A;
            granted_prev = 1'b0;
            if (RespValidM) begin
                done    = 1'b1;
                mem_gnt = 1'b0;
            end else if (mem_en) begin
                if (mem_be !== v.be || mem_addr !== v.maddr || mem_we !== v.we ||
                    (v.we && mem_wdata !== v.mwdata) || StallM !== 1'b1)
                    stable_ok = 1'b0;
                mem_gnt      = (en_cycles == v.dly);
                granted_prev = mem_gnt;
                en_cycles++;
            end else begin
                mem_gnt = 1'b0;
                if (StallM !== 1'b1) stable_ok = 1'b0;
            end
            if (!done) begin
                @(negedge clk);
                k++;
            end
        end
        check($sformatf("v%0d resp_seen", id), {31'd0, done}, 32'd1);
        check($sformatf("v%0d latency", id), k, v.lat);
        check($sformatf("v%0d en_cycles", id), en_cycles, v.en);
        check($sformatf("v%0d bus_fields", id), {31'd0, stable_ok}, 32'd1);
        check($sformatf("v%0d misalign", id), {31'd0, MisalignM}, {31'd0, v.mis});
        check($sformatf("v%0d buserr", id), {31'd0, BusErrM}, {31'd0, v.berr});
        check($sformatf("v%0d rdata", id), ReadDataM, v.rd);
        check($sformatf("v%0d stall_done", id), {31'd0, StallM}, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d resp_pulse", id), {30'd0, RespValidM, ReqReadyM}, 32'd1);
        check($sformatf("v%0d hold", id), {30'd0, MisalignM, BusErrM}, {30'd0, v.mis, v.berr});
        check($sformatf("v%0d rdata_hold", id), ReadDataM, v.rd);
    endtask

    initial begin
        //          we  f3      addr          wdata         rdata         dly  be       maddr    mwdata        rd            mis berr lat en
        vecs[0]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0,   4'b1111, 30'h40, 32'h0,        32'hFFFF_FF80, 0, 0, 3,  1};
        vecs[1]  = '{1'b1, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0,       3,   4'b1100, 30'h08, 32'hBEEF_BEEF, 32'hFFFF_FF80, 0, 0, 5,  4};
        vecs[2]  = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0,   4'b1111, 30'h0,  32'h0,        32'hFFFF_FF80, 1, 0, 1,  0};
        vecs[3]  = '{1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'h0,        255, 4'b1111, 30'h0,  32'h0,        32'hFFFF_FF80, 0, 1, 17, 16};
        vecs[4]  = '{1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h1234_8A56, 1,   4'b1111, 30'h40, 32'h0,        32'h0000_008A, 0, 0, 4,  2};
        vecs[5]  = '{1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h9ABC_0011, 0,   4'b1111, 30'h0,  32'h0,        32'hFFFF_9ABC, 0, 0, 3,  1};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_0008, 32'h0,        32'hCAFE_F00D, 2,   4'b1111, 30'h2,  32'h0,        32'hCAFE_F00D, 0, 0, 5,  3};
        vecs[7]  = '{1'b1, 3'b000, 32'h0000_0007, 32'h0000_00A5, 32'h0,       0,   4'b1000, 30'h1,  32'hA5A5_A5A5, 32'hCAFE_F00D, 0, 0, 2,  1};
        vecs[8]  = '{1'b1, 3'b010, 32'h0000_000C, 32'h1234_5678, 32'h0,       1,   4'b1111, 30'h3,  32'h1234_5678, 32'hCAFE_F00D, 0, 0, 3,  2};
        vecs[9]  = '{1'b1, 3'b001, 32'h0000_0021, 32'h0000_1111, 32'h0,       0,   4'b0000, 30'h0,  32'h0,        32'hCAFE_F00D, 1, 0, 1,  0};
        vecs[10] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_2222, 32'h0,       0,   4'b0000, 30'h0,  32'h0,        32'hCAFE_F00D, 1, 0, 1,  0};
        vecs[11] = '{1'b0, 3'b101, 32'h0000_0006, 32'h0,        32'h8001_7FFF, 0,   4'b1111, 30'h1,  32'h0,        32'h0000_8001, 0, 0, 3,  1};
        vecs[12] = '{1'b0, 3'b001, 32'h0000_0000, 32'h0,        32'h0000_8000, 0,   4'b1111, 30'h0,  32'h0,        32'hFFFF_8000, 0, 0, 3,  1};
        vecs[13] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0,   4'b1111, 30'h0,  32'h0,        32'hFFFF_8000, 1, 0, 1,  0};
        vecs[14] = '{1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 0,   4'b1111, 30'h0,  32'h0,        32'h0000_007F, 0, 0, 3,  1};

        reset      = 1'b0;
        ReqValidM  = 1'b0;
        MemWriteM  = 1'b0;
        funct3M    = 3'd0;
        AddrM      = 32'd0;
        WriteDataM = 32'd0;
        mem_gnt    = 1'b0;
        mem_rdata  = 32'd0;

        #12;
        check("rst ctrl", {26'd0, mem_en, mem_we, RespValidM, MisalignM, BusErrM, StallM}, 32'd0);
        check("rst ready", {31'd0, ReqReadyM}, 32'd1);
        check("rst be_addr", {mem_be, mem_addr}, 32'd0);
        check("rst wdata", mem_wdata, 32'd0);
        check("rst rdata", ReadDataM, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // Asynchronous reset while a load sits in REQ waiting for a grant
        @(negedge clk);
        ReqValidM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; AddrM = 32'h10;
        @(negedge clk);
        ReqValidM = 1'b0;
        @(negedge clk);
        check("areset pre en", {31'd0, mem_en}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("areset en", {31'd0, mem_en}, 32'd0);
        check("areset stall", {31'd0, StallM}, 32'd0);
        check("areset ready", {31'd0, ReqReadyM}, 32'd1);
        check("areset rdata", ReadDataM, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_vec(99, '{1'b1, 3'b010, 32'h0000_0010, 32'h0BAD_F00D, 32'h0, 1,
                      4'b1111, 30'h4, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0, 3, 2});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
